// File: rtl/gpr_wb_pkg.sv
// Shared types and default sizing for the GPR writeback arbiter and its MDU result buffer.
package gpr_wb_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREG_DEF  = 32;
    localparam int REG_IDX_W = $clog2(NREG_DEF);

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN_DEF-1:0]  value;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding MDU writeback requests; the head entry is visible
// combinationally so the arbiter can grant it in the same cycle.
module wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter type T     = wb_req_t,
    parameter int  DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  T                           din,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between pipeline writeback and buffered MDU results,
// and tracks MDU-pending destinations so ID can stall on hazards.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int NREG       = NREG_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    output logic                    iss_ready,
    input  logic                    pipe_valid,
    input  logic [$clog2(NREG)-1:0] pipe_rd,
    input  logic [XLEN-1:0]         pipe_value,
    output logic                    pipe_ready,
    input  logic                    mdu_valid,
    input  logic [$clog2(NREG)-1:0] mdu_rd,
    input  logic [XLEN-1:0]         mdu_value,
    output logic                    mdu_ready,
    input  logic [$clog2(NREG)-1:0] id_rs1,
    input  logic [$clog2(NREG)-1:0] id_rs2,
    input  logic [$clog2(NREG)-1:0] id_rd,
    output logic                    hazard_busy,
    output logic                    wb_rd_en,
    output logic [$clog2(NREG)-1:0] wb_rd,
    output logic [XLEN-1:0]         wb_rd_value
);

    localparam int IDX_W  = $clog2(NREG);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [IDX_W-1:0] rd;
        logic [XLEN-1:0]  value;
    } req_t;

    req_t              mdu_req;
    req_t              head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [NREG-1:0]   pending_reg, pending_next;
    logic              wb_rd_en_reg;
    logic [IDX_W-1:0]  wb_rd_reg;
    logic [XLEN-1:0]   wb_rd_value_reg;
    logic              pipe_cand, force_fifo, fifo_grant, pipe_grant;
    logic              head_commit, push;

    assign mdu_req = '{rd: mdu_rd, value: mdu_value};

    wb_fifo #(.T(req_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (fifo_grant),
        .din     (mdu_req),
        .head    (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Pipeline wins by default; a FIFO head that has lost MAX_WAIT times takes the port.
    always_comb begin
        pipe_cand   = pipe_valid && (pipe_rd != '0);
        force_fifo  = !fifo_empty && (wait_cnt_reg >= WAIT_W'(MAX_WAIT));
        fifo_grant  = reset_n && !fifo_empty && (force_fifo || !pipe_cand);
        pipe_grant  = reset_n && pipe_cand && !force_fifo;
        head_commit = fifo_grant && (head.rd != '0);
        iss_ready   = reset_n && !pending_reg[iss_rd];
        pipe_ready  = reset_n && !force_fifo;
        mdu_ready   = reset_n && (fifo_count < CNT_W'(FIFO_DEPTH));
        push        = mdu_valid && mdu_ready;
        hazard_busy = ((id_rs1 != '0) && pending_reg[id_rs1]) ||
                      ((id_rs2 != '0) && pending_reg[id_rs2]) ||
                      ((id_rd  != '0) && pending_reg[id_rd]);
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (fifo_empty || fifo_grant)
            wait_cnt_next = '0;
        else if (wait_cnt_reg < WAIT_W'(MAX_WAIT))
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    // A new issue can only target a non-pending rd, so set taking precedence is harmless.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
        if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
        end else begin : g_reg
            assign pending_next[gi] =
                (iss_valid && iss_ready && (iss_rd == IDX_W'(gi))) ||
                (pending_reg[gi] && !(head_commit && (head.rd == IDX_W'(gi))));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt_reg    <= '0;
            pending_reg     <= '0;
            wb_rd_en_reg    <= 1'b0;
            wb_rd_reg       <= '0;
            wb_rd_value_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            pending_reg  <= pending_next;
            wb_rd_en_reg <= pipe_grant || head_commit;
            if (pipe_grant) begin
                wb_rd_reg       <= pipe_rd;
                wb_rd_value_reg <= pipe_value;
            end else if (head_commit) begin
                wb_rd_reg       <= head.rd;
                wb_rd_value_reg <= head.value;
            end
        end
    end

    assign wb_rd_en    = wb_rd_en_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_rd_value = wb_rd_value_reg;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue/array reference model.
module tb_gpr_wb_arbiter;

    localparam int XLEN     = 64;
    localparam int NREG     = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            iss_valid = 1'b0;
    logic [4:0]      iss_rd = '0;
    logic            iss_ready;
    logic            pipe_valid = 1'b0;
    logic [4:0]      pipe_rd = '0;
    logic [XLEN-1:0] pipe_value = '0;
    logic            pipe_ready;
    logic            mdu_valid = 1'b0;
    logic [4:0]      mdu_rd = '0;
    logic [XLEN-1:0] mdu_value = '0;
    logic            mdu_ready;
    logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic            hazard_busy;
    logic            wb_rd_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_rd_value;

    gpr_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_value(pipe_value), .pipe_ready(pipe_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_value(mdu_value), .mdu_ready(mdu_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .hazard_busy(hazard_busy),
        .wb_rd_en(wb_rd_en), .wb_rd(wb_rd), .wb_rd_value(wb_rd_value)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a queue for the result buffer, a bit array of pending regs,
    // and a count of consecutive arbitration losses of the buffered head.
    typedef struct {
        int              rd;
        logic [XLEN-1:0] v;
    } ent_t;

    ent_t            q_m[$];
    bit              pend_m[NREG];
    int              loss_m = 0;
    logic            exp_en;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_val;

    always @(posedge clock) begin : model
        int   sz;
        bit   pipe_wins, fifo_wins, acc_iss;
        ent_t h;
        if (!reset_n) begin
            q_m.delete();
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            loss_m  = 0;
            exp_en  = 1'b0;
            exp_rd  = '0;
            exp_val = '0;
        end else begin
            sz        = q_m.size();
            pipe_wins = pipe_valid && (pipe_rd != 0) && !(sz > 0 && loss_m >= MAX_WAIT);
            fifo_wins = (sz > 0) && !pipe_wins;
            acc_iss   = iss_valid && !pend_m[iss_rd];
            exp_en    = 1'b0;
            if (pipe_wins) begin
                exp_en  = 1'b1;
                exp_rd  = pipe_rd;
                exp_val = pipe_value;
            end
            if (fifo_wins) begin
                h = q_m.pop_front();
                if (h.rd != 0) begin
                    exp_en     = 1'b1;
                    exp_rd     = 5'(h.rd);
                    exp_val    = h.v;
                    pend_m[h.rd] = 1'b0;
                end
            end
            if (acc_iss && iss_rd != 0) pend_m[iss_rd] = 1'b1;
            if (mdu_valid && sz < DEPTH) q_m.push_back('{rd: int'(mdu_rd), v: mdu_value});
            loss_m = (sz == 0 || fifo_wins) ? 0 : ((loss_m < MAX_WAIT) ? loss_m + 1 : MAX_WAIT);
        end
    end

    always @(negedge clock) begin : compare
        bit frc, hz;
        if (check_en) begin
            frc = (q_m.size() > 0) && (loss_m >= MAX_WAIT);
            hz  = (id_rs1 != 0 && pend_m[id_rs1]) || (id_rs2 != 0 && pend_m[id_rs2]) ||
                  (id_rd != 0 && pend_m[id_rd]);
            chk("m_iss_ready", iss_ready, reset_n && !pend_m[iss_rd]);
            chk("m_pipe_ready", pipe_ready, reset_n && !frc);
            chk("m_mdu_ready", mdu_ready, reset_n && (q_m.size() < DEPTH));
            chk("m_hazard", hazard_busy, hz);
            chk("m_wb_en", wb_rd_en, exp_en);
            chk("m_wb_rd", wb_rd, exp_rd);
            chk("m_wb_val", wb_rd_value, exp_val);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rd = 0; pipe_valid = 0; pipe_rd = 0; pipe_value = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_value = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    initial begin
        int   rdn, mk, stall_at, first_full, third_at;
        bit   pr, mr, pipe_taken, mdu_taken, iss_taken;
        int   got[$];
        int   iss_q[$];

        // 1: reset with every valid asserted
        reset_n = 0;
        iss_valid = 1; iss_rd = 3; pipe_valid = 1; pipe_rd = 2; pipe_value = 1;
        mdu_valid = 1; mdu_rd = 4; mdu_value = 2;
        cyc();
        check_en = 1'b1;
        repeat (2) begin
            chk("t1_iss_ready", iss_ready, 0);
            chk("t1_pipe_ready", pipe_ready, 0);
            chk("t1_mdu_ready", mdu_ready, 0);
            chk("t1_wb_en", wb_rd_en, 0);
            cyc();
        end
        idle();
        reset_n = 1;
        for (int r = 0; r < NREG; r++) begin
            id_rs1 = 5'(r); id_rs2 = 5'(r); id_rd = 5'(r);
            #1 chk("t1_hazard_clear", hazard_busy, 0);
            cyc();
        end
        idle();

        // 2: issue, hazard, commit of one MDU result
        iss_valid = 1; iss_rd = 5;
        #1 chk("t2_iss_ready", iss_ready, 1);
        cyc();
        iss_valid = 0; id_rs1 = 5;
        #1 chk("t2_hazard_set", hazard_busy, 1);
        mdu_valid = 1; mdu_rd = 5; mdu_value = 64'hABCD;
        cyc();
        mdu_valid = 0;
        chk("t2_no_early_commit", wb_rd_en, 0);
        chk("t2_hazard_held", hazard_busy, 1);
        cyc();
        chk("t2_wb_en", wb_rd_en, 1);
        chk("t2_wb_rd", wb_rd, 5);
        chk("t2_wb_val", wb_rd_value, 64'hABCD);
        chk("t2_hazard_cleared", hazard_busy, 0);
        cyc();
        chk("t2_wb_en_drop", wb_rd_en, 0);
        chk("t2_wb_rd_hold", wb_rd, 5);
        id_rs1 = 0;

        // 3: anti-starvation against a continuous pipe stream
        iss_valid = 1; iss_rd = 9;
        cyc();
        iss_valid = 0;
        rdn = 1; pipe_valid = 1; pipe_rd = 1; pipe_value = 101;
        mdu_valid = 1; mdu_rd = 9; mdu_value = 64'h9999;
        stall_at = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            pr = pipe_ready; mr = mdu_ready;
            if (!pr && stall_at < 0) stall_at = c;
            if (c == 6) chk("t3_pipe_resumes", pr, 1);
            cyc();
            if (mdu_valid && mr) mdu_valid = 0;
            if (pr) begin rdn++; pipe_rd = 5'(rdn); pipe_value = 64'(100 + rdn); end
            if (c == 5) begin
                chk("t3_forced_en", wb_rd_en, 1);
                chk("t3_forced_rd", wb_rd, 9);
                chk("t3_forced_val", wb_rd_value, 64'h9999);
            end
            if (c == 6) begin
                chk("t3_held_pipe_rd", wb_rd, 6);
                chk("t3_held_pipe_val", wb_rd_value, 106);
            end
        end
        pipe_valid = 0;
        chk("t3_stall_cycle", 64'(stall_at), 5);

        // 4: three MDU results into a two-entry buffer under pipe pressure
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1; iss_rd = 5'(10 + k);
            cyc();
        end
        iss_valid = 0;
        mk = 0; mdu_valid = 1; mdu_rd = 10; mdu_value = 1010;
        rdn = 0; pipe_valid = 1; pipe_rd = 1; pipe_value = 0;
        first_full = -1; third_at = -1;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            pr = pipe_ready; mr = mdu_ready;
            if (mdu_valid && !mr && first_full < 0) first_full = c;
            if (mdu_valid && mr && mk == 2) third_at = c;
            cyc();
            if (mdu_valid && mr) begin
                mk++;
                if (mk < 3) begin mdu_rd = 5'(10 + mk); mdu_value = 64'(1010 + mk); end
                else mdu_valid = 0;
            end
            if (pr) begin rdn++; pipe_rd = 5'(1 + rdn % 8); pipe_value = 64'(rdn); end
            if (wb_rd_en && wb_rd >= 10 && wb_rd <= 12) got.push_back(int'(wb_rd));
        end
        pipe_valid = 0;
        chk("t4_full_at", 64'(first_full), 2);
        chk("t4_third_at", 64'(third_at), 6);
        chk("t4_commits", 64'(got.size()), 3);
        for (int k = 0; k < 3; k++)
            chk("t4_order", (k < got.size()) ? 64'(got[k]) : 64'hFFFF, 64'(10 + k));

        // 5: WAW block and rd=0 issue
        iss_valid = 1; iss_rd = 7;
        #1 chk("t5_first_issue", iss_ready, 1);
        cyc();
        #1 chk("t5_waw_block", iss_ready, 0);
        iss_rd = 0;
        #1 chk("t5_rd0_ready", iss_ready, 1);
        cyc();
        iss_valid = 0; id_rd = 7;
        #1 chk("t5_pending7", hazard_busy, 1);
        id_rd = 0;
        mdu_valid = 1; mdu_rd = 0; mdu_value = 64'h55;
        cyc();
        mdu_valid = 0;
        cyc();
        chk("t5_rd0_no_commit", wb_rd_en, 0);
        mdu_valid = 1; mdu_rd = 7; mdu_value = 64'h77;
        cyc();
        mdu_valid = 0;
        cyc();
        chk("t5_rd7_en", wb_rd_en, 1);
        chk("t5_rd7_rd", wb_rd, 7);
        chk("t5_rd7_val", wb_rd_value, 64'h77);

        // 6: reset with buffered results and pending bits
        iss_valid = 1; iss_rd = 13;
        cyc();
        iss_rd = 14;
        cyc();
        iss_valid = 0;
        pipe_valid = 1; pipe_rd = 1; pipe_value = 1;
        mdu_valid = 1; mdu_rd = 13; mdu_value = 1313;
        cyc();
        mdu_rd = 14; mdu_value = 1414; pipe_rd = 2;
        cyc();
        mdu_valid = 0; pipe_valid = 0; reset_n = 0;
        cyc();
        cyc();
        reset_n = 1; id_rs1 = 13; id_rs2 = 14;
        #1 chk("t6_hazard_clear", hazard_busy, 0);
        chk("t6_mdu_ready", mdu_ready, 1);
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("t6_no_commit", wb_rd_en, 0);
        end
        idle();

        // Randomized traffic; the MDU stand-in returns results in issue order.
        iss_q.delete();
        pipe_taken = 1;
        for (int n = 0; n < 3000; n++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = 5'($urandom_range(0, NREG - 1));
            if (!pipe_valid || pipe_taken) begin
                pipe_valid = ($urandom_range(0, 3) != 0);
                pipe_rd    = 5'($urandom_range(0, NREG - 1));
                pipe_value = {$urandom, $urandom};
            end
            if (!mdu_valid && iss_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                mdu_valid = 1;
                mdu_rd    = 5'(iss_q[0]);
                mdu_value = {$urandom, $urandom};
            end
            id_rs1 = 5'($urandom_range(0, NREG - 1));
            id_rs2 = 5'($urandom_range(0, NREG - 1));
            id_rd  = 5'($urandom_range(0, NREG - 1));
            @(negedge clock);
            pipe_taken = pipe_ready;
            mdu_taken  = mdu_valid && mdu_ready;
            iss_taken  = iss_valid && iss_ready;
            cyc();
            if (!reset_n) begin
                iss_q.delete();
                mdu_valid = 0;
            end else begin
                if (mdu_taken) begin
                    void'(iss_q.pop_front());
                    mdu_valid = 0;
                end
                if (iss_taken) iss_q.push_back(int'(iss_rd));
            end
        end
        reset_n = 1;
        idle();
        repeat (4) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
